// File: rtl/mem64_responder.sv
// 64-bit data-memory responder: one request at a time, LATENCY wait states, sub-word access, error reporting.
// Define MEM64_RESP_MISALIGN_ERR_EN to fault misaligned requests instead of silently aligning them down.
module mem64_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        reqReady, rspValid, rspErr;
  logic [63:0] rspRdata;
  logic        heldWr, heldUns;
  logic [1:0]  heldSize;
  logic [63:0] heldAddr, heldWdata;
  logic [63:0] mem [DEPTH_WORDS];

  // With zero latency the access commits on the accepting edge, so decode straight from the inputs.
  logic        idle, curWr, curUns, commit;
  logic [1:0]  curSize;
  logic [63:0] curAddr, curWdata;
  assign idle     = (state == IDLE);
  assign curWr    = idle ? req_wr       : heldWr;
  assign curUns   = idle ? req_unsigned : heldUns;
  assign curSize  = idle ? req_size     : heldSize;
  assign curAddr  = idle ? req_addr     : heldAddr;
  assign curWdata = idle ? req_wdata    : heldWdata;
  assign commit   = (idle && req_valid && LATENCY == 0) || (state == WAIT && cnt == 4'd1);

  logic [2:0]  offset, sizeMask, effOff;
  logic [7:0]  lenMask, byteMask;
  logic [63:0] bitMask, oldWord, newWord, shifted, loadData;
  logic        inRange, accErr;
  logic [IW-1:0] memIdx;

  always_comb begin
    offset  = curAddr[2:0];
    inRange = curAddr[63:3] < 61'(DEPTH_WORDS);
    case (curSize)
      2'd0:    begin sizeMask = 3'b000; lenMask = 8'h01; end
      2'd1:    begin sizeMask = 3'b001; lenMask = 8'h03; end
      2'd2:    begin sizeMask = 3'b011; lenMask = 8'h0F; end
      default: begin sizeMask = 3'b111; lenMask = 8'hFF; end
    endcase
`ifdef MEM64_RESP_MISALIGN_ERR_EN
    effOff = offset;
    accErr = !inRange || (|(offset & sizeMask));
`else
    effOff = offset & ~sizeMask;
    accErr = !inRange;
`endif
    memIdx   = inRange ? curAddr[IW+2:3] : '0;
    oldWord  = mem[memIdx];
    byteMask = lenMask << effOff;
    bitMask  = '0;
    for (int b = 0; b < 8; b++) bitMask[8*b +: 8] = {8{byteMask[b]}};
    newWord  = (oldWord & ~bitMask) | ((curWdata << {effOff, 3'b000}) & bitMask);
    shifted  = oldWord >> {effOff, 3'b000};
    case (curSize)
      2'd0:    loadData = curUns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    loadData = curUns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    loadData = curUns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: loadData = shifted;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      rspRdata <= '0;
      rspErr   <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      rspRdata <= '0;
      rspErr   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          heldWr    <= req_wr;
          heldUns   <= req_unsigned;
          heldSize  <= req_size;
          heldAddr  <= req_addr;
          heldWdata <= req_wdata;
          cnt       <= 4'(LATENCY);
          reqReady  <= 1'b0;
          state     <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
        end
      endcase
      if (commit) begin
        rspValid <= 1'b1;
        rspErr   <= accErr;
        rspRdata <= (accErr || curWr) ? 64'd0 : loadData;
      end
    end
  end

  // Storage is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (commit && !Reset && curWr && !accErr) mem[memIdx] <= newWord;
  end

  assign req_ready = reqReady;
  assign rsp_valid = rspValid;
  assign rsp_rdata = rspRdata;
  assign rsp_err   = rspErr;
endmodule

// File: tb/tb_mem64_responder.sv
// Bench for mem64_responder: directed vector table, byte-array reference model with random traffic, reset and zero-latency sequences.
module tb_mem64_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        Clk = 0, Reset = 1;
  logic        reqValid = 0, reqWr = 0, reqUns = 0, u1Valid = 0;
  logic [1:0]  reqSize = 0;
  logic [63:0] reqAddr = 0, reqWdata = 0;
  logic        reqReady, rspValid, rspErr, u1Ready, u1RspValid, u1Err;
  logic [63:0] rspRdata, u1Rdata;

  int total = 0, bad = 0;
  logic [7:0] refMem [DEPTH*8];

  always #5 Clk = ~Clk;

  mem64_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(reqValid), .req_ready(reqReady), .req_wr(reqWr),
    .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr));

  mem64_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u1 (
    .Clk(Clk), .Reset(Reset), .req_valid(u1Valid), .req_ready(u1Ready), .req_wr(reqWr),
    .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(u1RspValid), .rsp_rdata(u1Rdata), .rsp_err(u1Err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access computed from the address/size rules directly.
  task automatic refApply(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er);
    longint unsigned n, base;
    n  = 64'd1 << sz;
    er = (a >> 3) >= DEPTH;
`ifdef MEM64_RESP_MISALIGN_ERR_EN
    if (a % n != 0) er = 1;
    base = a;
`else
    base = a - (a % n);
`endif
    rd = 0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < int'(n); i++) refMem[int'(base) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(n); i++) rd[8*i +: 8] = refMem[int'(base) + i];
        if (!uns && n < 8 && rd[8*n-1]) rd = rd | ~((64'd1 << (8*n)) - 1);
      end
    end
  endtask

  // Issue one request to the main DUT (called just after a rising edge, DUT idle) and check timing.
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er);
    int n;
    chk("readyIdle", 64'(reqReady), 64'd1);
    reqWr = wr; reqSize = sz; reqUns = uns; reqAddr = a; reqWdata = wd; reqValid = 1;
    @(posedge Clk); #1;
    reqValid = 0;
    n = 1;
    while (!rspValid && n < 40) begin
      chk("readyLowWait", 64'(reqReady), 64'd0);
      @(posedge Clk); #1;
      n++;
    end
    chk("rspLatency", 64'(n), 64'(LAT + 1));
    chk("readyLowResp", 64'(reqReady), 64'd0);
    rd = rspRdata; er = rspErr;
    @(posedge Clk); #1;
    chk("rspCleared", {rspValid, rspErr, rspRdata}, 64'd0);
    chk("readyAfter", 64'(reqReady), 64'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] expRd;
    logic        expErr;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [63:0] rd, mrd, w;
    logic er, mer, wr, uns;
    logic [1:0] sz;
    logic [63:0] a;

    tbl.push_back('{1, 3, 0, 64'h10,  64'h1122334455667788, 64'h0, 0});
    tbl.push_back('{0, 3, 0, 64'h10,  64'h0, 64'h1122334455667788, 0});
    tbl.push_back('{1, 3, 0, 64'h10,  64'h0, 64'h0, 0});
    tbl.push_back('{1, 0, 0, 64'h13,  64'h80, 64'h0, 0});
    tbl.push_back('{0, 0, 0, 64'h13,  64'h0, 64'hFFFFFFFFFFFFFF80, 0});
    tbl.push_back('{0, 0, 1, 64'h13,  64'h0, 64'h80, 0});
    tbl.push_back('{0, 3, 0, 64'h10,  64'h0, 64'h0000000080000000, 0});
    tbl.push_back('{1, 3, 0, 64'h0,   64'hCAFE, 64'h0, 0});
    tbl.push_back('{0, 3, 0, 64'h800, 64'h0, 64'h0, 1});
    tbl.push_back('{1, 3, 0, 64'h800, 64'h1234, 64'h0, 1});
    tbl.push_back('{0, 3, 1, 64'h0,   64'h0, 64'hCAFE, 0});
    tbl.push_back('{1, 1, 0, 64'h16,  64'hBEEF, 64'h0, 0});
    tbl.push_back('{0, 1, 0, 64'h16,  64'h0, 64'hFFFFFFFFFFFFBEEF, 0});
    tbl.push_back('{0, 2, 1, 64'h14,  64'h0, 64'hBEEF0000, 0});
`ifdef MEM64_RESP_MISALIGN_ERR_EN
    tbl.push_back('{0, 2, 1, 64'h12,  64'h0, 64'h0, 1});
`else
    tbl.push_back('{0, 2, 1, 64'h12,  64'h0, 64'h80000000, 0});
`endif

    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    chk("rstReady", 64'(reqReady), 64'd1);
    chk("rstValid", 64'(rspValid), 64'd0);
    chk("rstRdata", rspRdata, 64'd0);
    chk("rstErr", 64'(rspErr), 64'd0);

    foreach (tbl[i]) begin
      doReq(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er);
      chk($sformatf("vec%0d.rdata", i), rd, tbl[i].expRd);
      chk($sformatf("vec%0d.err", i), 64'(er), 64'(tbl[i].expErr));
    end

    // Give words 0..15 known contents, then random traffic against the reference model.
    for (int wi = 0; wi < 16; wi++) begin
      w = {$urandom, $urandom};
      refApply(1, 3, 0, 64'(wi * 8), w, mrd, mer);
      doReq(1, 3, 0, 64'(wi * 8), w, rd, er);
      chk("initErr", 64'(er), 64'd0);
    end
    for (int k = 0; k < 300; k++) begin
      wr  = $urandom_range(0, 2) == 0;
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        a = {($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0, 32'($urandom_range(DEPTH * 8, DEPTH * 8 + 4000))};
      else
        a = 64'($urandom_range(0, 127));
      w = {$urandom, $urandom};
      refApply(wr, sz, uns, a, w, mrd, mer);
      doReq(wr, sz, uns, a, w, rd, er);
      chk($sformatf("rnd%0d.rdata", k), rd, mrd);
      chk($sformatf("rnd%0d.err", k), 64'(er), 64'(mer));
    end

    // Reset during the first wait cycle drops a pending store.
    reqWr = 1; reqSize = 3; reqUns = 0; reqAddr = 0; reqWdata = 64'hDEAD; reqValid = 1;
    @(posedge Clk); #1;
    reqValid = 0; Reset = 1;
    @(posedge Clk); #1;
    Reset = 0;
    chk("midRstReady", 64'(reqReady), 64'd1);
    chk("midRstValid", 64'(rspValid), 64'd0);
    refApply(0, 3, 0, 64'h0, 64'h0, mrd, mer);
    doReq(0, 3, 0, 64'h0, 64'h0, rd, er);
    chk("midRstOldData", rd, mrd);

    // Zero-latency instance with request held: response every other cycle, ready low only in RESP.
    reqWr = 0; reqSize = 3; reqAddr = 0; u1Valid = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      chk($sformatf("lat0.valid%0d", i), 64'(u1RspValid), 64'(i % 2 == 0));
      chk($sformatf("lat0.ready%0d", i), 64'(u1Ready), 64'(i % 2 == 1));
    end
    u1Valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
